// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the fp32 multiplier issue path.
package fp_mul_pkg;

    localparam int FP32_WIDTH   = 32;
    localparam int MAX_ID_WIDTH = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // One slot of the tag pipe that shadows the multiplier.
    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin arbiter: lowest index at or after ptr wins, wrapping.
module rr_arbiter_onehot
    import fp_mul_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    // Walk from the farthest offset down so the closest requester overwrites last.
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (en && req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp32_mul_issue_arbiter.sv
// Shares one pipelined fp32 multiplier among NUM_REQ requesters and steers
// each result back to its owner via a tag pipe matched to the multiplier latency.
module fp32_mul_issue_arbiter
    import fp_mul_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = FP32_WIDTH,
    parameter int MUL_LATENCY = 6,
    parameter int ID_WIDTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic                          hold,
    output logic                          mul_valid,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [DATA_WIDTH-1:0]         mul_result,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [clog2(MUL_LATENCY+1):0] inflight,
    output logic                          idle
);

    localparam int CNT_W = clog2(MUL_LATENCY + 1) + 1;

    // Handshake: a transfer happens when req_valid[i] & req_ready[i]; req_ready
    // is one-hot or zero, may depend on req_valid, and is forced low by hold.
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  xfer;

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  mul_valid_q, mul_valid_d;
    logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0] mul_b_q, mul_b_d;
    logic [ID_WIDTH-1:0]   issue_id_q, issue_id_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;

    tag_t                  tag_q [MUL_LATENCY];
    tag_t                  tag_d;
    tag_t                  tag_out;

    rr_arbiter_onehot #(
        .N    (NUM_REQ),
        .ID_W (ID_WIDTH)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .en       (!hold),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign tag_out   = tag_q[MUL_LATENCY-1];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mul_valid_d = xfer;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        issue_id_d  = issue_id_q;
        if (xfer) begin
            rr_ptr_d   = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
            mul_a_d    = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
            mul_b_d    = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
            issue_id_d = grant_id;
        end
        tag_d.valid = mul_valid_q;
        tag_d.id    = MAX_ID_WIDTH'(issue_id_q);
        inflight_d  = inflight_q + CNT_W'(xfer) - CNT_W'(tag_out.valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id_q  <= '0;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            issue_id_q  <= issue_id_d;
            inflight_q  <= inflight_d;
        end
    end

    // Clearing the tags on reset discards any results still inside the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_out.valid) begin
            rsp_valid[tag_out.id] = 1'b1;
        end
    end

    assign rsp_data  = mul_result;
    assign rsp_id    = tag_out.id[ID_WIDTH-1:0];
    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == '0) && !xfer && !mul_valid_q;

endmodule

// File: tb/tb_fp32_mul_issue_arbiter.sv
// Directed, table-driven bench for fp32_mul_issue_arbiter with a delay-line multiplier model.
module tb_fp32_mul_issue_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int L  = 6;
    localparam int CW = 4;

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic         hold;
        logic [N-1:0] exp_ready;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           hold;
    logic           mul_valid;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [W-1:0]   mul_result;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;
    logic [CW-1:0]  inflight;
    logic           idle;

    fp32_mul_issue_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (W),
        .MUL_LATENCY (L),
        .ID_WIDTH    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .hold       (hold),
        .mul_valid  (mul_valid),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .inflight   (inflight),
        .idle       (idle)
    );

    // Clock/reset and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stand-in product: data only has to travel with the right tag.
    function automatic logic [W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a ^ b;
    endfunction

    logic [W-1:0] mdl_q [L];
    always @(posedge clk) begin
        mdl_q[0] <= mul_valid ? model_mul(mul_a, mul_b) : '0;
        for (int i = 1; i < L; i++) mdl_q[i] <= mdl_q[i-1];
    end
    assign mul_result = mdl_q[L-1];

    // Checking
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic logic [1:0] onehot2id(input logic [N-1:0] v);
        logic [1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) if (v[i]) id = 2'(i);
        return id;
    endfunction

    function automatic logic [W-1:0] lane_a(input int k, input int i);
        if (k == 0) return 32'h4000_0000;
        return {8'h3F, 8'(k), 8'(i), 8'h11};
    endfunction

    function automatic logic [W-1:0] lane_b(input int k, input int i);
        if (k == 0) return 32'h4040_0000;
        return {8'h41, 8'(i), 8'(k), 8'h22};
    endfunction

    // Scoreboard: exp_q holds {due cycle, id, data}; iss_q holds {due cycle, a, b}.
    logic [65:0] exp_q [$];
    logic [95:0] iss_q [$];
    logic        xfer_exp = 1'b0;
    int          exp_infl = 0;
    int          max_infl = 0;

    always @(negedge clk) begin
        logic        resp_due;
        logic        iss_due;
        logic [65:0] re;
        logic [95:0] ie;
        if (rst) begin
            exp_q.delete();
            iss_q.delete();
            exp_infl = 0;
        end else begin
            resp_due = (exp_q.size() > 0) && (exp_q[0][65:34] == 32'(cyc));
            iss_due  = (iss_q.size() > 0) && (iss_q[0][95:64] == 32'(cyc));
            if (resp_due) begin
                re = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1) << re[33:32]);
                chk("rsp_id", 32'(rsp_id), 32'(re[33:32]));
                chk("rsp_data", rsp_data, re[31:0]);
            end else begin
                chk("rsp_valid_quiet", 32'(rsp_valid), 32'd0);
            end
            if (iss_due) begin
                ie = iss_q.pop_front();
                chk("mul_valid", 32'(mul_valid), 32'd1);
                chk("mul_a", mul_a, ie[63:32]);
                chk("mul_b", mul_b, ie[31:0]);
            end else begin
                chk("mul_valid_quiet", 32'(mul_valid), 32'd0);
            end
            chk("inflight", 32'(inflight), 32'(exp_infl));
            chk("idle", 32'(idle), 32'(exp_infl == 0 && !iss_due && !xfer_exp));
            if (int'(inflight) > max_infl) max_infl = int'(inflight);
            exp_infl = exp_infl + (xfer_exp ? 1 : 0) - (resp_due ? 1 : 0);
        end
    end

    // Driver
    vec_t tbl [$];

    task automatic add(input logic r, input logic [N-1:0] v, input logic h, input logic [N-1:0] e);
        vec_t x;
        x.rst = r; x.valid = v; x.hold = h; x.exp_ready = e;
        tbl.push_back(x);
    endtask

    task automatic idle_rows(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 4'b0000, 1'b0, 4'b0000);
    endtask

    initial begin
        logic [1:0] id;
        rst = 1'b1; req_valid = '0; hold = 1'b0; req_a = '0; req_b = '0;

        // single requester (row 0 lands on cycle 10)
        add(1'b0, 4'b0100, 1'b0, 4'b0100);
        idle_rows(8);
        // saturation from reset
        add(1'b1, 4'b0000, 1'b0, 4'b0000);
        for (int i = 0; i < 8; i++) add(1'b0, 4'b1111, 1'b0, 4'(1 << (i % 4)));
        idle_rows(8);
        // sparse fairness: steer ptr to 2, then 3,1,3
        add(1'b0, 4'b0010, 1'b0, 4'b0010);
        add(1'b0, 4'b1010, 1'b0, 4'b1000);
        add(1'b0, 4'b1010, 1'b0, 4'b0010);
        add(1'b0, 4'b1010, 1'b0, 4'b1000);
        idle_rows(8);
        // hold with 4 in flight
        for (int i = 0; i < 4; i++) add(1'b0, 4'b1111, 1'b0, 4'(1 << i));
        for (int i = 0; i < 9; i++) add(1'b0, 4'b1111, 1'b1, 4'b0000);
        // reset with 3 in flight, then the lowest valid index wins
        add(1'b0, 4'b0111, 1'b0, 4'b0001);
        add(1'b0, 4'b0111, 1'b0, 4'b0010);
        add(1'b0, 4'b0111, 1'b0, 4'b0100);
        add(1'b1, 4'b0000, 1'b0, 4'b0000);
        idle_rows(7);
        // transfer coinciding with a response
        add(1'b0, 4'b1010, 1'b0, 4'b0010);
        idle_rows(6);
        add(1'b0, 4'b0001, 1'b0, 4'b0001);
        idle_rows(8);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_mul_a", mul_a, 32'd0);
        chk("reset_mul_b", mul_b, 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_inflight", 32'(inflight), 32'd0);
        chk("reset_idle", 32'(idle), 32'd1);
        while (cyc < 9) begin
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            rst       = tbl[k].rst;
            req_valid = tbl[k].valid;
            hold      = tbl[k].hold;
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W] = lane_a(k, i);
                req_b[i*W +: W] = lane_b(k, i);
            end
            xfer_exp = !tbl[k].rst && (tbl[k].exp_ready != '0);
            #1;
            chk("req_ready", 32'(req_ready), 32'(tbl[k].exp_ready));
            if (xfer_exp) begin
                id = onehot2id(tbl[k].exp_ready);
                exp_q.push_back({32'(cyc + 1 + L), id, model_mul(lane_a(k, int'(id)), lane_b(k, int'(id)))});
                iss_q.push_back({32'(cyc + 1), lane_a(k, int'(id)), lane_b(k, int'(id))});
            end
            if (k > 0 && tbl[k-1].rst) begin
                chk("post_reset_mul_a", mul_a, 32'd0);
                chk("post_reset_mul_b", mul_b, 32'd0);
                chk("post_reset_rsp_id", 32'(rsp_id), 32'd0);
                chk("post_reset_inflight", 32'(inflight), 32'd0);
            end
        end

        @(posedge clk);
        #1;
        req_valid = '0;
        hold      = 1'b0;
        xfer_exp  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_rsp_drained", 32'(exp_q.size()), 32'd0);
        chk("scoreboard_iss_drained", 32'(iss_q.size()), 32'd0);
        chk("inflight_peak", 32'(max_infl), 32'(L + 1));
        chk("final_idle", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
